// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OS = 8;

  localparam logic [2:0] SAMPLE_LO  = 3'd3;
  localparam logic [2:0] SAMPLE_MID = 3'd4;
  localparam logic [2:0] SAMPLE_HI  = 3'd5;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional phase accumulator; tick is the registered carry out.
// Held at phase zero while run is low so each frame starts aligned.
module uart_baud_tick #(
  parameter int Width = 10,
  parameter int Incr  = 78
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  logic [Width-1:0] acc;
  logic [Width:0]   sum;

  assign sum = {1'b0, acc} + (Width+1)'(Incr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[Width-1:0];
      tick <= sum[Width];
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 oversampling UART receiver. Define UART_RX_MAJORITY_EN to take
// each bit as a 2-of-3 vote over sub-ticks 3..5 instead of one sample.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int Width = 10,
  parameter int Incr  = 78,
  parameter int Os    = OS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rin,
  output logic [7:0] dout,
  output logic       ready,
  output logic       rxerr,
  output logic       busy
);

  localparam int CW = $clog2(Os);

  rx_state_t   state;
  logic        rs_meta;
  logic        rs;
  logic        tick;
  logic        run;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        samp;
  logic        bitv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta <= IDLE_LEVEL;
      rs      <= IDLE_LEVEL;
    end else begin
      rs_meta <= rin;
      rs      <= rs_meta;
    end
  end

  assign run = (state != IDLE);

  uart_baud_tick #(
    .Width(Width),
    .Incr (Incr)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  assign cnt_n = cnt + 1'b1;

`ifdef UART_RX_MAJORITY_EN
  logic v_lo;
  logic v_mid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_lo  <= 1'b0;
      v_mid <= 1'b0;
    end else if (tick) begin
      if (cnt_n == SAMPLE_LO)  v_lo  <= rs;
      if (cnt_n == SAMPLE_MID) v_mid <= rs;
    end
  end

  assign samp = tick && (cnt_n == SAMPLE_HI);
  assign bitv = (v_lo & v_mid) | (v_lo & rs) | (v_mid & rs);
`else
  assign samp = tick && (cnt_n == SAMPLE_MID);
  assign bitv = rs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      dout  <= '0;
      ready <= 1'b0;
      rxerr <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= 1'b0;
      rxerr <= 1'b0;
      if (tick) cnt <= cnt_n;
      unique case (state)
        IDLE: begin
          if (rs != IDLE_LEVEL) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (samp) begin
            if (bitv) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (samp) begin
            sh  <= {bitv, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (samp) begin
            if (bitv) begin
              dout  <= sh;
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              rxerr <= 1'b1;
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          // one error per low period; wait for mark before rearming
          if (rs == IDLE_LEVEL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random
// back-to-back bytes compared against an expected-byte queue.
module tb_uart_rx_os;

  localparam int BIT_CLK = 104;

  logic       clk = 1'b0;
  logic       reset;
  logic       rin;
  logic [7:0] dout;
  logic       ready;
  logic       rxerr;
  logic       busy;

  int checks = 0;
  int passed = 0;

  int   rdy_cnt;
  int   err_cnt;
  int   proto_err = 0;
  bit   busy_seen;
  logic prev_ready = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx_os dut (
    .clk  (clk),
    .reset(reset),
    .rin  (rin),
    .dout (dout),
    .ready(ready),
    .rxerr(rxerr),
    .busy (busy)
  );

  always @(negedge clk) begin
    if (ready) begin
      rdy_cnt++;
      got_q.push_back(dout);
    end
    if (rxerr) err_cnt++;
    if (busy) busy_seen = 1'b1;
    if ((ready && rxerr) || (ready && prev_ready) || (rxerr && prev_err))
      proto_err++;
    prev_ready = ready;
    prev_err   = rxerr;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rdy_cnt   = 0;
    err_cnt   = 0;
    busy_seen = 1'b0;
    got_q.delete();
  endtask

  function automatic logic [7:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  // gbit: frame bit that gets a 13-clk inverted pulse centred on the
  // clock the sub-tick-4 sample reads (52+7 clks into that bit)
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int gbit, input int nbits);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == gbit) begin
        rin = fr[i];
        wait_clk(52);
        rin = ~fr[i];
        wait_clk(13);
        rin = fr[i];
        wait_clk(BIT_CLK - 65);
      end else begin
        rin = fr[i];
        wait_clk(BIT_CLK);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rin   = 1'b1;
    wait_clk(3);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout);
    else passed++;
    checks++;
    if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready);
    else passed++;
    checks++;
    if (rxerr !== 1'b0) $display("FAIL reset_rxerr got %b want 0", rxerr);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_clk(20);
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'h71, 1'b1, -1, 10);
    rin = 1'b1;
    wait_clk(150);
    checks++;
    if (rdy_cnt !== 1) $display("FAIL single_ready_cnt got %0d want 1", rdy_cnt);
    else passed++;
    checks++;
    if (got(0) !== 8'h71) $display("FAIL single_dout got %h want 71", got(0));
    else passed++;
    checks++;
    if (err_cnt !== 0) $display("FAIL single_rxerr_cnt got %0d want 0", err_cnt);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_break();
    clear_mon();
    send_frame(8'h55, 1'b0, -1, 10);
    wait_clk(2000);
    checks++;
    if (err_cnt !== 1) $display("FAIL break_rxerr_cnt got %0d want 1", err_cnt);
    else passed++;
    checks++;
    if (rdy_cnt !== 0) $display("FAIL break_ready_cnt got %0d want 0", rdy_cnt);
    else passed++;
    checks++;
    if (dout !== 8'h71) $display("FAIL break_dout got %h want 71", dout);
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL break_busy_held got %b want 1", busy);
    else passed++;
    rin = 1'b1;
    wait_clk(10);
    checks++;
    if (busy !== 1'b0) $display("FAIL break_busy_release got %b want 0", busy);
    else passed++;
    checks++;
    if (err_cnt !== 1) $display("FAIL break_rxerr_final got %0d want 1", err_cnt);
    else passed++;
    wait_clk(200);
  endtask

  task automatic test_glitch();
    clear_mon();
    rin = 1'b0;
    wait_clk(20);
    rin = 1'b1;
    wait_clk(BIT_CLK);
    checks++;
    if (rdy_cnt !== 0 || err_cnt !== 0)
      $display("FAIL glitch_pulses got ready=%0d rxerr=%0d want 0/0",
               rdy_cnt, err_cnt);
    else passed++;
    checks++;
    if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen got %b want 1", busy_seen);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_end got %b want 0", busy);
    else passed++;
    wait_clk(100);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3];
    exp = '{8'h73, 8'h30, 8'h63};
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1, 10);
    rin = 1'b1;
    wait_clk(200);
    checks++;
    if (rdy_cnt !== 3) $display("FAIL b2b_ready_cnt got %0d want 3", rdy_cnt);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got(i) !== exp[i])
        $display("FAIL b2b_dout%0d got %h want %h", i, got(i), exp[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, 5);
    reset = 1'b1;
    rin   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({dout, ready, rxerr, busy} !== 11'd0)
        $display("FAIL midreset_outputs%0d got dout=%h r=%b e=%b b=%b want 0",
                 i, dout, ready, rxerr, busy);
      else passed++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    wait_clk(300);
    send_frame(8'h63, 1'b1, -1, 10);
    rin = 1'b1;
    wait_clk(200);
    checks++;
    if (rdy_cnt !== 1 || err_cnt !== 0)
      $display("FAIL midreset_pulses got ready=%0d rxerr=%0d want 1/0",
               rdy_cnt, err_cnt);
    else passed++;
    checks++;
    if (got(0) !== 8'h63) $display("FAIL midreset_dout got %h want 63", got(0));
    else passed++;
  endtask

  task automatic test_majority();
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    clear_mon();
    send_frame(8'h00, 1'b1, 4, 10);
    rin = 1'b1;
    wait_clk(200);
    checks++;
    if (rdy_cnt !== 1) $display("FAIL vote_ready_cnt got %0d want 1", rdy_cnt);
    else passed++;
    checks++;
    if (got(0) !== want) $display("FAIL vote_dout got %h want %h", got(0), want);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] model_q[$];
    logic [7:0] d;
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      model_q.push_back(d);
      send_frame(d, 1'b1, -1, 10);
      rin = 1'b1;
      wait_clk(int'($urandom_range(150, 0)));
    end
    wait_clk(200);
    checks++;
    if (rdy_cnt !== model_q.size())
      $display("FAIL rand_ready_cnt got %0d want %0d", rdy_cnt, model_q.size());
    else passed++;
    foreach (model_q[i]) begin
      checks++;
      if (got(i) !== model_q[i])
        $display("FAIL rand_dout%0d got %h want %h", i, got(i), model_q[i]);
      else passed++;
    end
    checks++;
    if (err_cnt !== 0) $display("FAIL rand_rxerr_cnt got %0d want 0", err_cnt);
    else passed++;
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err !== 0)
      $display("FAIL pulse_shape got %0d violations want 0", proto_err);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    rin   = 1'b1;
    test_reset();
    test_single();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_majority();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
